rtc_mux_bus_xfer: RTL and testbench
===================================

Name: rtc_mux_bus_xfer

Overview:
Parametrised transfer engine for a multiplexed address/data RTC bus with active-low strobes (V3023 class).
- Runs one complete access per request: address phase, then a read or write data phase.
- All phase widths are parameters in clk cycles.
- Adds over the previous generation: ready/done handshake, latched request fields, tri-state bus drive and a registered read-data capture point.
- Sits between the register-access FSM (host side) and the FPGA pad tri-state buffers (RTC side).

Parameters:
DATA_W  8  width of the address/data bus and of addr/wdata/rdata
T_ADS  2  address setup: cycles ad_n low before cs_n falls
T_ADDR  6  cycles cs_n/wr_n low during the address strobe
T_AH  2  address hold after strobes rise, ad_n still low
T_GAP  10  recovery between address phase and data phase
T_DATA  8  cycles cs_n plus rd_n or wr_n low in the data phase
T_SAMPLE  6  data-phase cycle (1..T_DATA) at whose end bus_in is captured on reads
T_DH  2  write-data hold / bus turnaround after data strobes rise
CNT_W  5  phase counter width; must hold max(T_*)-1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  1  start access; sampled only while ready=1
rd_nwr  in  1  1=read, 0=write; latched with req
addr  in  DATA_W  register address; latched with req
wdata  in  DATA_W  write data; latched with req
ready  out  1  engine idle, req will be accepted
done  out  1  one-cycle pulse at end of access
rdata  out  DATA_W  captured read data; valid from done, held until next read's capture
ad_n  out  1  ~A/D: 0=address on bus, 1=data
cs_n  out  1  chip select, active low
rd_n  out  1  read strobe, active low
wr_n  out  1  write strobe, active low
bus_out  out  DATA_W  value driven onto pads
bus_oe  out  1  pad output enable, 1=drive
bus_in  in  DATA_W  pad input value

Behaviour:
Reset values and output timing
- Reset: state IDLE; ready=1, done=0, ad_n=cs_n=rd_n=wr_n=1, bus_oe=0, bus_out=0, rdata=0.
- All outputs are registered; no combinational path from inputs to outputs.

Phase counter
- cnt is cleared to 0 on every state change.
- Each timed state exits on the edge where cnt==T_x-1, so it lasts exactly T_x cycles.

State sequence
- IDLE: ready=1.
  - On req=1, latch rd_nwr/addr/wdata, set ready=0, ad_n=0, bus_oe=1, bus_out=addr, and go to ADS.
  - req=0 stays in IDLE.
- ADS (T_ADS): strobes high. On exit: cs_n=0, wr_n=0, go to ADDR.
- ADDR (T_ADDR): cs_n=wr_n=0, bus_out=addr. On exit: cs_n=wr_n=1, go to AHLD.
- AHLD (T_AH): ad_n=0, addr still driven. On exit: ad_n=1, then
  - write: bus_out=wdata, bus_oe=1;
  - read: bus_oe=0.
  - Go to GAP.
- GAP (T_GAP): all strobes high. On exit: cs_n=0, then rd_n=0 for a read or wr_n=0 for a write. Go to DATA.
- DATA (T_DATA): strobes held low.
  - Read: on the edge where cnt==T_SAMPLE-1, rdata<=bus_in.
  - On exit: cs_n=rd_n=wr_n=1, go to DHLD.
- DHLD (T_DH): write data still driven (write only). On exit: bus_oe=0, done=1, ready=1, go to IDLE.

Timing
- done is high for exactly one cycle.
- Latency: done is high in the cycle starting L = T_ADS+T_ADDR+T_AH+T_GAP+T_DATA+T_DH edges after the accepting edge (default L=30).
- Back-to-back: req=1 during the done cycle is accepted, giving a new ADS on the next edge with no idle gap.

Boundary rules
- req while ready=0: ignored, never queued.
- Changes to addr/wdata/rd_nwr mid-access: no effect.
- rd_n and wr_n are never low simultaneously.
- cs_n is never low while bus_oe and bus direction mismatch.
- Reset mid-access: on the next edge all strobes go high, bus_oe=0, the engine returns to IDLE, and done is not pulsed.
- Parameter legality, checked by elaboration assertions: all T_* >= 1; 1 <= T_SAMPLE <= T_DATA.

Decomposition:
- Package rtc_bus_pkg:
  - state enum (IDLE, ADS, ADDR, AHLD, GAP, DATA, DHLD);
  - default timing localparams for the V3023 at 100 MHz;
  - a function returning total latency L for the bench.
- Sub-module rtc_phase_timer: cnt register with clear-on-state-change and an expire flag, compare value selected by state. The main FSM instantiates it once.

Test Plan:
1. Defaults, req=1 for one cycle, rd_nwr=0, addr=0x0A, wdata=0x5C.
   - Expected: ad_n low for 10 cycles, with cs_n/wr_n low cycles 2-7.
   - Expected: cs_n/wr_n low again cycles 20-27 with bus_out=0x5C and bus_oe=1; done at cycle 30.
2. Read, addr=0x03, bus_in=0x47 at DATA cycle 5 and 0xFF elsewhere.
   - Expected: rd_n low cycles 20-27, wr_n stays 1, bus_oe=0 from cycle 10.
   - Expected: rdata=0x47 at done.
3. Back-to-back: a write, then a read with req held high through the first done.
   - Expected: the second ADS starts the cycle after done; total 60 cycles; ready=0 except the done cycles.
4. req pulsed while busy at cycle 15 with addr=0x7F.
   - Expected: ignored; only one done; bus never shows 0x7F.
5. reset asserted during DATA of a write.
   - Expected: next cycle cs_n=wr_n=1, bus_oe=0, ready=1; no done; rdata unchanged.
6. Override T_ADS=1, T_DATA=3, T_SAMPLE=3, all others 1.
   - Expected: read done at cycle 8; rdata equals bus_in from the last DATA cycle.

Source files
------------

// File: rtl/rtc_mux_bus_xfer_pkg.sv
// rtc_bus_pkg: shared types and default timing for the multiplexed
// address/data RTC bus transfer engine (V3023 class part).
//   state_t        - transfer engine state encoding
//   DEF_T_*        - default phase widths in clk cycles (100 MHz clock)
//   total_latency  - accept-edge to done-cycle distance for a timing set
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADS,
    S_ADDR,
    S_AHLD,
    S_GAP,
    S_DATA,
    S_DHLD
  } state_t;

  // V3023 minimum timings rounded up to whole 10 ns cycles.
  localparam int DEF_T_ADS    = 2;
  localparam int DEF_T_ADDR   = 6;
  localparam int DEF_T_AH     = 2;
  localparam int DEF_T_GAP    = 10;
  localparam int DEF_T_DATA   = 8;
  localparam int DEF_T_SAMPLE = 6;
  localparam int DEF_T_DH     = 2;

  function automatic int total_latency(input int t_ads, input int t_addr,
                                       input int t_ah, input int t_gap,
                                       input int t_data, input int t_dh);
    return t_ads + t_addr + t_ah + t_gap + t_data + t_dh;
  endfunction

endpackage

// File: rtl/rtc_mux_bus_xfer_phase_timer.sv
// rtc_phase_timer: phase counter for the transfer engine.
//   clk, reset  - clock, synchronous active-high reset
//   i_state     - current engine state; selects the phase length
//   i_clear     - engine is changing state on this edge
//   o_cnt       - cycles spent so far in the current state (0-based)
//   o_expire    - last cycle of the current timed state
module rtc_phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int T_ADS  = DEF_T_ADS,
  parameter int T_ADDR = DEF_T_ADDR,
  parameter int T_AH   = DEF_T_AH,
  parameter int T_GAP  = DEF_T_GAP,
  parameter int T_DATA = DEF_T_DATA,
  parameter int T_DH   = DEF_T_DH,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  state_t           i_state,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;

  always_comb begin
    w_last = '0;
    case (i_state)
      S_ADS:   w_last = CNT_W'(T_ADS - 1);
      S_ADDR:  w_last = CNT_W'(T_ADDR - 1);
      S_AHLD:  w_last = CNT_W'(T_AH - 1);
      S_GAP:   w_last = CNT_W'(T_GAP - 1);
      S_DATA:  w_last = CNT_W'(T_DATA - 1);
      S_DHLD:  w_last = CNT_W'(T_DH - 1);
      default: w_last = '0;
    endcase
  end

  assign o_expire = (i_state != S_IDLE) && (r_cnt == w_last);
  assign o_cnt    = r_cnt;

  // Held at zero while idle so the first timed state always starts at 0.
  always_ff @(posedge clk) begin
    if (reset || i_clear || (i_state == S_IDLE)) r_cnt <= '0;
    else                                         r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/rtc_mux_bus_xfer.sv
// rtc_mux_bus_xfer: one complete multiplexed-bus access per request
// (address phase, then read or write data phase), all outputs registered.
//   clk, reset               - clock, synchronous active-high reset
//   req, rd_nwr, addr, wdata - host request; fields latched on acceptance
//   ready, done              - engine idle / one-cycle end-of-access pulse
//   rdata                    - captured read data, held until next capture
//   ad_n, cs_n, rd_n, wr_n   - active-low bus strobes
//   bus_out, bus_oe, bus_in  - pad tri-state buffer interface
module rtc_mux_bus_xfer
  import rtc_bus_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int T_ADS    = DEF_T_ADS,
  parameter int T_ADDR   = DEF_T_ADDR,
  parameter int T_AH     = DEF_T_AH,
  parameter int T_GAP    = DEF_T_GAP,
  parameter int T_DATA   = DEF_T_DATA,
  parameter int T_SAMPLE = DEF_T_SAMPLE,
  parameter int T_DH     = DEF_T_DH,
  parameter int CNT_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rd_nwr,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              ad_n,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in
);

  localparam int  CNT_MAX  = 1 << CNT_W;
  localparam bit  BAD_TIME = (T_ADS < 1) || (T_ADDR < 1) || (T_AH < 1) ||
                             (T_GAP < 1) || (T_DATA < 1) || (T_DH < 1) ||
                             (T_SAMPLE < 1) || (T_SAMPLE > T_DATA);
  localparam bit  BAD_CNT  = (T_ADS > CNT_MAX) || (T_ADDR > CNT_MAX) ||
                             (T_AH > CNT_MAX) || (T_GAP > CNT_MAX) ||
                             (T_DATA > CNT_MAX) || (T_DH > CNT_MAX);

  if (BAD_TIME) begin : g_bad_timing
    $error("rtc_mux_bus_xfer: every T_* must be >= 1 and 1 <= T_SAMPLE <= T_DATA");
  end
  if (BAD_CNT) begin : g_bad_cnt_w
    $error("rtc_mux_bus_xfer: CNT_W too narrow for the phase widths");
  end

  state_t            r_state, w_next;
  logic              r_ready, r_done, r_ad_n, r_cs_n, r_rd_n, r_wr_n, r_bus_oe;
  logic              w_ready, w_done, w_ad_n, w_cs_n, w_rd_n, w_wr_n, w_bus_oe;
  logic [DATA_W-1:0] r_bus_out, r_rdata, w_bus_out, w_rdata;
  logic              r_rd;
  logic [DATA_W-1:0] r_addr, r_wdata;
  logic              w_latch;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_expire;

  rtc_phase_timer #(
    .T_ADS (T_ADS),
    .T_ADDR(T_ADDR),
    .T_AH  (T_AH),
    .T_GAP (T_GAP),
    .T_DATA(T_DATA),
    .T_DH  (T_DH),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_state (r_state),
    .i_clear (w_next != r_state),
    .o_cnt   (w_cnt),
    .o_expire(w_expire)
  );

  // Next-state and next-output values; every output is taken from a
  // register, so each strobe edge is scheduled one state early.
  always_comb begin
    w_next    = r_state;
    w_ready   = r_ready;
    w_done    = 1'b0;
    w_ad_n    = r_ad_n;
    w_cs_n    = r_cs_n;
    w_rd_n    = r_rd_n;
    w_wr_n    = r_wr_n;
    w_bus_oe  = r_bus_oe;
    w_bus_out = r_bus_out;
    w_rdata   = r_rdata;
    w_latch   = 1'b0;
    case (r_state)
      S_IDLE: if (req) begin
        w_latch   = 1'b1;
        w_ready   = 1'b0;
        w_ad_n    = 1'b0;
        w_bus_oe  = 1'b1;
        w_bus_out = addr;
        w_next    = S_ADS;
      end
      S_ADS: if (w_expire) begin
        w_cs_n = 1'b0;
        w_wr_n = 1'b0;
        w_next = S_ADDR;
      end
      S_ADDR: if (w_expire) begin
        w_cs_n = 1'b1;
        w_wr_n = 1'b1;
        w_next = S_AHLD;
      end
      S_AHLD: if (w_expire) begin
        w_ad_n = 1'b1;
        // Reads release the bus here so it is turned around well before cs_n.
        if (r_rd) begin
          w_bus_oe = 1'b0;
        end else begin
          w_bus_oe  = 1'b1;
          w_bus_out = r_wdata;
        end
        w_next = S_GAP;
      end
      S_GAP: if (w_expire) begin
        w_cs_n = 1'b0;
        if (r_rd) w_rd_n = 1'b0;
        else      w_wr_n = 1'b0;
        w_next = S_DATA;
      end
      S_DATA: begin
        if (r_rd && (w_cnt == CNT_W'(T_SAMPLE - 1))) w_rdata = bus_in;
        if (w_expire) begin
          w_cs_n = 1'b1;
          w_rd_n = 1'b1;
          w_wr_n = 1'b1;
          w_next = S_DHLD;
        end
      end
      S_DHLD: if (w_expire) begin
        w_bus_oe = 1'b0;
        w_done   = 1'b1;
        w_ready  = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_ad_n    <= 1'b1;
      r_cs_n    <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_bus_oe  <= 1'b0;
      r_bus_out <= '0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_next;
      r_ready   <= w_ready;
      r_done    <= w_done;
      r_ad_n    <= w_ad_n;
      r_cs_n    <= w_cs_n;
      r_rd_n    <= w_rd_n;
      r_wr_n    <= w_wr_n;
      r_bus_oe  <= w_bus_oe;
      r_bus_out <= w_bus_out;
      r_rdata   <= w_rdata;
    end
  end

  // Request fields are only meaningful after acceptance; no reset needed.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_rd    <= rd_nwr;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  assign ready   = r_ready;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign ad_n    = r_ad_n;
  assign cs_n    = r_cs_n;
  assign rd_n    = r_rd_n;
  assign wr_n    = r_wr_n;
  assign bus_oe  = r_bus_oe;
  assign bus_out = r_bus_out;

endmodule

// File: tb/tb_rtc_mux_bus_xfer.sv
// Directed bench for rtc_mux_bus_xfer: a default-timing instance and a
// short-timing instance share stimulus; sel picks which one is observed.
module tb_rtc_mux_bus_xfer;
  import rtc_bus_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, req, rd_nwr, sel;
  logic [7:0] addr, wdata, bus_in;

  logic       a_ready, a_done, a_ad_n, a_cs_n, a_rd_n, a_wr_n, a_bus_oe;
  logic [7:0] a_rdata, a_bus_out;
  logic       b_ready, b_done, b_ad_n, b_cs_n, b_rd_n, b_wr_n, b_bus_oe;
  logic [7:0] b_rdata, b_bus_out;
  logic       req_a, req_b;

  assign req_a = req & ~sel;
  assign req_b = req & sel;

  rtc_mux_bus_xfer u_dut_a (
    .clk(clk), .reset(reset), .req(req_a), .rd_nwr(rd_nwr), .addr(addr),
    .wdata(wdata), .ready(a_ready), .done(a_done), .rdata(a_rdata),
    .ad_n(a_ad_n), .cs_n(a_cs_n), .rd_n(a_rd_n), .wr_n(a_wr_n),
    .bus_out(a_bus_out), .bus_oe(a_bus_oe), .bus_in(bus_in)
  );

  rtc_mux_bus_xfer #(
    .T_ADS(1), .T_ADDR(1), .T_AH(1), .T_GAP(1), .T_DATA(3), .T_SAMPLE(3), .T_DH(1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .rd_nwr(rd_nwr), .addr(addr),
    .wdata(wdata), .ready(b_ready), .done(b_done), .rdata(b_rdata),
    .ad_n(b_ad_n), .cs_n(b_cs_n), .rd_n(b_rd_n), .wr_n(b_wr_n),
    .bus_out(b_bus_out), .bus_oe(b_bus_oe), .bus_in(bus_in)
  );

  logic       ready, done, ad_n, cs_n, rd_n, wr_n, bus_oe;
  logic [7:0] rdata, bus_out;
  assign ready   = sel ? b_ready   : a_ready;
  assign done    = sel ? b_done    : a_done;
  assign ad_n    = sel ? b_ad_n    : a_ad_n;
  assign cs_n    = sel ? b_cs_n    : a_cs_n;
  assign rd_n    = sel ? b_rd_n    : a_rd_n;
  assign wr_n    = sel ? b_wr_n    : a_wr_n;
  assign bus_oe  = sel ? b_bus_oe  : a_bus_oe;
  assign rdata   = sel ? b_rdata   : a_rdata;
  assign bus_out = sel ? b_bus_out : a_bus_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rd;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb[$];

  logic [7:0] last_rd[2];
  int t_ads, t_addr, t_ah, t_gap, t_data, t_sample, t_dh, lat;
  logic       cur_rd;
  logic [7:0] cur_addr, cur_wd, cur_rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_timing(input bit short_t);
    if (short_t) begin
      t_ads = 1; t_addr = 1; t_ah = 1; t_gap = 1; t_data = 3; t_sample = 3; t_dh = 1;
    end else begin
      t_ads = 2; t_addr = 6; t_ah = 2; t_gap = 10; t_data = 8; t_sample = 6; t_dh = 2;
    end
    lat = total_latency(t_ads, t_addr, t_ah, t_gap, t_data, t_dh);
  endtask

  // Called at a negedge; the request is accepted on the following posedge.
  task automatic issue(input logic rd, input logic [7:0] a, input logic [7:0] wd,
                       input logic [7:0] rv);
    exp_t e;
    int   idx;
    idx      = sel ? 1 : 0;
    req      = 1'b1;
    rd_nwr   = rd;
    addr     = a;
    wdata    = wd;
    bus_in   = 8'hFF;
    e.rd     = rd;
    e.rdata  = rd ? rv : last_rd[idx];
    last_rd[idx] = e.rdata;
    sb.push_back(e);
    cur_rd   = rd;
    cur_addr = a;
    cur_wd   = wd;
    cur_rv   = rv;
  endtask

  // Steps through one access cycle by cycle (k = cycles after the accept
  // edge), checking the bus waveform against the phase windows; returns at
  // the negedge of the done cycle.
  task automatic watch(input bit hold, input int poke_at, input int abort_at,
                       output int done_cyc);
    int a_end, d0, n;
    bit seen, aborted, busy, in_as, in_ds, oe_e;
    logic [14:0] ev, ov;
    logic [7:0]  bo_e;
    exp_t e;
    a_end    = t_ads + t_addr + t_ah;
    d0       = a_end + t_gap;
    seen     = 1'b0;
    aborted  = 1'b0;
    done_cyc = -1;
    for (int k = 0; k <= lat + 4; k++) begin
      @(negedge clk);
      busy  = (k < lat);
      in_as = (k >= t_ads) && (k < t_ads + t_addr);
      in_ds = (k >= d0) && (k < d0 + t_data);
      oe_e  = busy && ((k < a_end) || !cur_rd);
      bo_e  = (k < a_end) ? cur_addr : cur_wd;
      ev = {!(k < a_end), !(in_as || in_ds), !(in_ds && cur_rd),
            !(in_as || (in_ds && !cur_rd)), oe_e, !busy, !busy,
            oe_e ? bo_e : 8'h00};
      ov = {ad_n, cs_n, rd_n, wr_n, bus_oe, ready, done,
            oe_e ? bus_out : 8'h00};
      chk($sformatf("wave@%0d", k), ov, ev);
      if (done) begin
        seen     = 1'b1;
        done_cyc = cyc;
        e        = sb.pop_front();
        chk("done_latency", k, lat);
        chk("rdata_at_done", rdata, e.rdata);
        break;
      end
      if (k == abort_at) begin
        reset = 1'b1;
        e = sb.pop_back();
        @(negedge clk);
        chk("rst_mid_ctl", {ad_n, cs_n, rd_n, wr_n, bus_oe, ready, done}, 7'b1111010);
        chk("rst_mid_rdata", rdata, last_rd[sel ? 1 : 0]);
        reset   = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (k == poke_at) begin
        req    = 1'b1;
        addr   = 8'h7F;
        rd_nwr = ~cur_rd;
      end else if (!hold) begin
        req = 1'b0;
      end
      if (cur_rd) bus_in = (k == d0 + t_sample - 1) ? cur_rv : 8'hFF;
    end
    if (aborted) begin
      n = 0;
      repeat (35) begin
        @(negedge clk);
        if (done) n++;
      end
      chk("rst_no_done", n, 0);
    end else begin
      chk("done_seen", seen, 1'b1);
    end
  endtask

  initial begin
    int d1, d2, n;
    reset = 1'b1; req = 1'b0; rd_nwr = 1'b0; sel = 1'b0;
    addr = 8'h00; wdata = 8'h00; bus_in = 8'hFF;
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    set_timing(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_ctl_a", {a_ad_n, a_cs_n, a_rd_n, a_wr_n, a_bus_oe, a_ready, a_done}, 7'b1111010);
    chk("rst_data_a", {a_bus_out, a_rdata}, 16'h0000);
    chk("rst_ctl_b", {b_ad_n, b_cs_n, b_rd_n, b_wr_n, b_bus_oe, b_ready, b_done}, 7'b1111010);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {ad_n, cs_n, rd_n, wr_n, bus_oe, ready, done}, 7'b1111010);

    // Plain write with default timing.
    issue(1'b0, 8'h0A, 8'h5C, 8'h00);
    watch(1'b0, -1, -1, d1);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || !ready) n++;
    end
    chk("idle_quiet", n, 0);

    // Reset in the middle of a write data phase.
    issue(1'b0, 8'h33, 8'hC7, 8'h00);
    watch(1'b0, -1, t_ads + t_addr + t_ah + t_gap + 2, d1);

    // Read with the sample landing on the T_SAMPLE cycle only.
    @(negedge clk);
    issue(1'b1, 8'h03, 8'h00, 8'h47);
    watch(1'b0, -1, -1, d1);

    // Back-to-back write then read, req held through the first done.
    @(negedge clk);
    issue(1'b0, 8'h21, 8'hA5, 8'h00);
    watch(1'b1, -1, -1, d1);
    issue(1'b1, 8'h44, 8'h00, 8'h3C);
    watch(1'b0, -1, -1, d2);
    chk("b2b_spacing", d2 - d1, lat + 1);

    // Request poked while busy must be dropped.
    @(negedge clk);
    issue(1'b0, 8'h11, 8'h22, 8'h00);
    watch(1'b0, 15, -1, d1);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("poke_no_extra_done", n, 0);
    chk("sb_empty", sb.size(), 0);

    // Short-timing instance: read with capture on the last data cycle.
    sel = 1'b1;
    set_timing(1'b1);
    @(negedge clk);
    issue(1'b1, 8'h12, 8'h00, 8'hC3);
    watch(1'b0, -1, -1, d1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
